// File: rtl/mc_controller_hs.sv
// mc_controller_hs: multicycle MIPS-subset control unit with memory ready
// handshake, per-access timeout, sticky error state and retire counter.
//
// Ports:
//   clk, rst (async, active-low)
//   instruction[31:0]  IR contents (opcode [31:26], funct [5:0])
//   zeroflag           ALU zero result of the current cycle
//   mem_ready          memory completes the access requested this cycle
//   PCWrite..ALUSrcA   1-bit datapath controls
//   ALUSrcB[1:0]       00 regB, 01 const 4, 10 sext imm, 11 shifted imm
//   PCSrc[1:0]         00 ALU, 01 jump target, 10 ALUOut, 11 reg A
//   ALUoperation       and 000, or 001, add 010, sub 110, slt 111 (zero-extended)
//   retire             pulse in the final cycle of each instruction
//   instr_count        retired-instruction counter (wraps)
//   error, err_code    sticky error flag; 01 illegal, 10 memory timeout
module mc_controller_hs #(
   parameter int ALUOP_W     = 3,
   parameter int MEM_TIMEOUT = 15,
   parameter int CNT_W       = 16
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [31:0]        instruction,
   input  logic               zeroflag,
   input  logic               mem_ready,
   output logic               PCWrite,
   output logic               IorD,
   output logic               MemWrite,
   output logic               MemRead,
   output logic               IRWrite,
   output logic               RegDst,
   output logic               WriteRegSel,
   output logic               MemtoReg,
   output logic               WriteDataSel,
   output logic               RegWrite,
   output logic               ALUSrcA,
   output logic [1:0]         ALUSrcB,
   output logic [1:0]         PCSrc,
   output logic [ALUOP_W-1:0] ALUoperation,
   output logic               retire,
   output logic [CNT_W-1:0]   instr_count,
   output logic               error,
   output logic [1:0]         err_code
);

   typedef enum logic [3:0] {
      S_IF, S_ID, S_EX_R, S_EX_I, S_WB_R, S_WB_I, S_MEM_ADDR, S_MEM_RD,
      S_MEM_WB, S_MEM_WR, S_BR, S_J, S_JAL, S_JR, S_ERR
   } state_t;

   localparam logic [2:0] OP_AND = 3'b000;
   localparam logic [2:0] OP_OR  = 3'b001;
   localparam logic [2:0] OP_ADD = 3'b010;
   localparam logic [2:0] OP_SUB = 3'b110;
   localparam logic [2:0] OP_SLT = 3'b111;

   // Counter only has to reach MEM_TIMEOUT-1; with the timeout disabled it
   // just wraps and is never compared.
   localparam int WC_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
   localparam logic [WC_W-1:0] TO_LAST = WC_W'((MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0);

   state_t state, state_n;
   logic [WC_W-1:0] wcnt;
   logic [5:0] opc, fn;
   logic r_alu, r_jr, mem_state, timeout, ret_i;
   logic [1:0] code_n;
   logic [2:0] rop, iop, aop;
   logic unused_ir;

   assign opc       = instruction[31:26];
   assign fn        = instruction[5:0];
   assign unused_ir = ^instruction[25:6];

   // R-type ALU op from funct; also tells whether the funct is legal.
   always_comb begin
      rop   = OP_ADD;
      r_alu = 1'b1;
      case (fn)
         6'b100000: rop = OP_ADD;
         6'b100010: rop = OP_SUB;
         6'b100100: rop = OP_AND;
         6'b100101: rop = OP_OR;
         6'b101010: rop = OP_SLT;
         default:   r_alu = 1'b0;
      endcase
   end
   assign r_jr = (fn == 6'b001000);

   always_comb begin
      case (opc)
         6'b001100: iop = OP_AND;
         6'b001010: iop = OP_SLT;
         default:   iop = OP_ADD;
      endcase
   end

   assign mem_state = (state == S_IF) || (state == S_MEM_RD) || (state == S_MEM_WR);
   // A ready in the last allowed cycle beats the timeout.
   assign timeout   = (MEM_TIMEOUT > 0) && mem_state && !mem_ready && (wcnt == TO_LAST);

   // state register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= S_IF;
      else      state <= state_n;
   end

   // next state
   always_comb begin
      state_n = state;
      code_n  = 2'b00;
      case (state)
         S_IF: begin
            if (timeout)        begin state_n = S_ERR; code_n = 2'b10; end
            else if (mem_ready) state_n = S_ID;
         end
         S_ID: begin
            case (opc)
               6'b000000: begin
                  if (r_jr)       state_n = S_JR;
                  else if (r_alu) state_n = S_EX_R;
                  else begin state_n = S_ERR; code_n = 2'b01; end
               end
               6'b001000, 6'b001100, 6'b001010: state_n = S_EX_I;
               6'b100011, 6'b101011:            state_n = S_MEM_ADDR;
               6'b000100, 6'b000101:            state_n = S_BR;
               6'b000010:                       state_n = S_J;
               6'b000011:                       state_n = S_JAL;
               default: begin state_n = S_ERR; code_n = 2'b01; end
            endcase
         end
         S_EX_R:     state_n = S_WB_R;
         S_EX_I:     state_n = S_WB_I;
         S_MEM_ADDR: state_n = opc[3] ? S_MEM_WR : S_MEM_RD;
         S_MEM_RD: begin
            if (timeout)        begin state_n = S_ERR; code_n = 2'b10; end
            else if (mem_ready) state_n = S_MEM_WB;
         end
         S_MEM_WR: begin
            if (timeout)        begin state_n = S_ERR; code_n = 2'b10; end
            else if (mem_ready) state_n = S_IF;
         end
         S_ERR:   state_n = S_ERR;
         default: state_n = S_IF;
      endcase
   end

   // wait counter, retire counter, sticky error
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wcnt        <= '0;
         instr_count <= '0;
         error       <= 1'b0;
         err_code    <= 2'b00;
      end else begin
         // Any state change clears it, which covers entry to every wait state.
         if (state_n != state)            wcnt <= '0;
         else if (mem_state && !mem_ready) wcnt <= wcnt + WC_W'(1);
         if (ret_i) instr_count <= instr_count + CNT_W'(1);
         if (state != S_ERR && state_n == S_ERR) begin
            error    <= 1'b1;
            err_code <= code_n;
         end
      end
   end

   // outputs
   always_comb begin
      PCWrite = 1'b0; IorD = 1'b0; MemWrite = 1'b0; MemRead = 1'b0;
      IRWrite = 1'b0; RegDst = 1'b0; WriteRegSel = 1'b0; MemtoReg = 1'b0;
      WriteDataSel = 1'b0; RegWrite = 1'b0; ALUSrcA = 1'b0;
      ALUSrcB = 2'b00; PCSrc = 2'b00; aop = OP_AND; ret_i = 1'b0;
      case (state)
         S_IF: begin
            MemRead = 1'b1; ALUSrcB = 2'b01; aop = OP_ADD;
            IRWrite = mem_ready; PCWrite = mem_ready;
         end
         S_ID:       begin ALUSrcB = 2'b11; aop = OP_ADD; end
         S_EX_R:     begin ALUSrcA = 1'b1; aop = rop; end
         S_EX_I:     begin ALUSrcA = 1'b1; ALUSrcB = 2'b10; aop = iop; end
         S_WB_R:     begin RegDst = 1'b1; RegWrite = 1'b1; ret_i = 1'b1; end
         S_WB_I:     begin RegWrite = 1'b1; ret_i = 1'b1; end
         S_MEM_ADDR: begin ALUSrcA = 1'b1; ALUSrcB = 2'b10; aop = OP_ADD; end
         S_MEM_RD:   begin IorD = 1'b1; MemRead = 1'b1; end
         S_MEM_WB:   begin MemtoReg = 1'b1; RegWrite = 1'b1; ret_i = 1'b1; end
         S_MEM_WR: begin
            // The write is withheld in the cycle that times out.
            IorD = 1'b1; MemWrite = !timeout; ret_i = mem_ready;
         end
         S_BR: begin
            ALUSrcA = 1'b1; aop = OP_SUB; PCSrc = 2'b10; ret_i = 1'b1;
            PCWrite = opc[0] ? !zeroflag : zeroflag;
         end
         S_J:   begin PCSrc = 2'b01; PCWrite = 1'b1; ret_i = 1'b1; end
         S_JAL: begin
            PCSrc = 2'b01; PCWrite = 1'b1; WriteRegSel = 1'b1;
            WriteDataSel = 1'b1; RegWrite = 1'b1; ret_i = 1'b1;
         end
         S_JR:    begin PCSrc = 2'b11; PCWrite = 1'b1; ret_i = 1'b1; end
         default: ;
      endcase
      retire       = ret_i;
      ALUoperation = ALUOP_W'(aop);
      // Reset forces every control low at once, not just at the next edge.
      if (!rst) begin
         PCWrite = 1'b0; IorD = 1'b0; MemWrite = 1'b0; MemRead = 1'b0;
         IRWrite = 1'b0; RegDst = 1'b0; WriteRegSel = 1'b0; MemtoReg = 1'b0;
         WriteDataSel = 1'b0; RegWrite = 1'b0; ALUSrcA = 1'b0;
         ALUSrcB = 2'b00; PCSrc = 2'b00; ALUoperation = '0; retire = 1'b0;
      end
   end

endmodule

// File: tb/tb_mc_controller_hs.sv
// Self-checking bench for mc_controller_hs: per-cycle comparison of all
// outputs against an instruction-level micro-step model.
module tb_mc_controller_hs;

   localparam int CW = 8;  // narrow counter so the wrap is reachable quickly

   logic clk = 1'b0, rst = 1'b0;
   logic [31:0] instruction = '0;
   logic zeroflag = 1'b0, mem_ready = 1'b0;
   logic PCWrite, IorD, MemWrite, MemRead, IRWrite, RegDst, WriteRegSel;
   logic MemtoReg, WriteDataSel, RegWrite, ALUSrcA, retire, error;
   logic [1:0] ALUSrcB, PCSrc, err_code;
   logic [2:0] ALUoperation;
   logic [CW-1:0] instr_count;

   mc_controller_hs #(.ALUOP_W(3), .MEM_TIMEOUT(15), .CNT_W(CW)) dut (
      .clk(clk), .rst(rst), .instruction(instruction), .zeroflag(zeroflag),
      .mem_ready(mem_ready), .PCWrite(PCWrite), .IorD(IorD), .MemWrite(MemWrite),
      .MemRead(MemRead), .IRWrite(IRWrite), .RegDst(RegDst),
      .WriteRegSel(WriteRegSel), .MemtoReg(MemtoReg), .WriteDataSel(WriteDataSel),
      .RegWrite(RegWrite), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .PCSrc(PCSrc),
      .ALUoperation(ALUoperation), .retire(retire), .instr_count(instr_count),
      .error(error), .err_code(err_code)
   );

   always #5 clk = ~clk;

   typedef enum {P_IF, P_ID, P_EXR, P_EXI, P_WBR, P_WBI, P_MA, P_MRD, P_MWB,
                 P_MWR, P_BR, P_J, P_JAL, P_JR, P_ERR} phase_t;

   int checks = 0, errors = 0;
   logic [CW-1:0] exp_cnt = '0;
   logic exp_err = 1'b0;
   logic [1:0] exp_code = 2'b00;

   localparam logic [31:0] I_ADD = 32'h0123_4820;
   localparam logic [31:0] I_LW  = 32'h8C22_0004;
   localparam logic [31:0] I_SW  = 32'hAC22_0008;
   localparam logic [31:0] I_BEQ = 32'h1022_0003;
   localparam logic [31:0] I_BNE = 32'h1422_0003;
   localparam logic [31:0] I_J   = 32'h0800_0010;
   localparam logic [31:0] I_JR  = 32'h03E0_0008;

   function automatic logic [21:0] observed();
      return {PCWrite, IorD, MemWrite, MemRead, IRWrite, RegDst, WriteRegSel,
              MemtoReg, WriteDataSel, RegWrite, ALUSrcA, ALUSrcB, PCSrc,
              ALUoperation, retire, error, err_code};
   endfunction

   // Expected datapath controls for one micro-step, straight from the
   // per-step control table.
   function automatic logic [18:0] exp_out(phase_t p, logic [31:0] ins, logic rdy, logic zf);
      logic pcw, iord, mw, mr, irw, rd, wrs, m2r, wds, rw, sa, ret;
      logic [1:0] sb, ps;
      logic [2:0] op;
      {pcw, iord, mw, mr, irw, rd, wrs, m2r, wds, rw, sa, ret} = '0;
      sb = 2'b00; ps = 2'b00; op = 3'b000;
      case (p)
         P_IF:  begin mr = 1; sb = 2'b01; op = 3'b010; irw = rdy; pcw = rdy; end
         P_ID:  begin sb = 2'b11; op = 3'b010; end
         P_EXR: begin
            sa = 1;
            case (ins[5:0])
               6'b100010: op = 3'b110;
               6'b100100: op = 3'b000;
               6'b100101: op = 3'b001;
               6'b101010: op = 3'b111;
               default:   op = 3'b010;
            endcase
         end
         P_EXI: begin
            sa = 1; sb = 2'b10;
            op = (ins[31:26] == 6'b001100) ? 3'b000 :
                 (ins[31:26] == 6'b001010) ? 3'b111 : 3'b010;
         end
         P_WBR: begin rd = 1; rw = 1; ret = 1; end
         P_WBI: begin rw = 1; ret = 1; end
         P_MA:  begin sa = 1; sb = 2'b10; op = 3'b010; end
         P_MRD: begin iord = 1; mr = 1; end
         P_MWB: begin m2r = 1; rw = 1; ret = 1; end
         P_MWR: begin iord = 1; mw = 1; ret = rdy; end
         P_BR:  begin
            sa = 1; op = 3'b110; ps = 2'b10; ret = 1;
            pcw = (ins[31:26] == 6'b000101) ? !zf : zf;
         end
         P_J:   begin ps = 2'b01; pcw = 1; ret = 1; end
         P_JAL: begin ps = 2'b01; pcw = 1; wrs = 1; wds = 1; rw = 1; ret = 1; end
         P_JR:  begin ps = 2'b11; pcw = 1; ret = 1; end
         default: ;
      endcase
      return {pcw, iord, mw, mr, irw, rd, wrs, m2r, wds, rw, sa, sb, ps, op, ret};
   endfunction

   // Drive one cycle (called at posedge+1) and compare outputs at negedge.
   task automatic step(input phase_t p, input logic [31:0] ins, input logic rdy, input logic zf);
      logic [21:0] e, g;
      instruction = ins; mem_ready = rdy; zeroflag = zf;
      @(negedge clk);
      g = observed();
      e = {exp_out(p, ins, rdy, zf), exp_err, exp_code};
      checks++;
      if (g !== e) begin
         errors++;
         $display("FAIL step %s ins=%h rdy=%0b: got %b want %b", p.name(), ins, rdy, g, e);
      end
      @(posedge clk); #1;
   endtask

   task automatic check_cnt(input string name);
      checks++;
      if (instr_count !== exp_cnt) begin
         errors++;
         $display("FAIL %s instr_count: got %0d want %0d", name, instr_count, exp_cnt);
      end
   endtask

   // Run one legal instruction. wif/wmem: wait cycles in IF / the memory
   // step; negative picks a random count 0..3.
   task automatic run_instr(input logic [31:0] ins, input logic zf, input int wif, input int wmem);
      phase_t plan[$];
      int w;
      plan.push_back(P_IF);
      plan.push_back(P_ID);
      case (ins[31:26])
         6'b000000: if (ins[5:0] == 6'b001000) plan.push_back(P_JR);
                    else begin plan.push_back(P_EXR); plan.push_back(P_WBR); end
         6'b100011: begin plan.push_back(P_MA); plan.push_back(P_MRD); plan.push_back(P_MWB); end
         6'b101011: begin plan.push_back(P_MA); plan.push_back(P_MWR); end
         6'b000100, 6'b000101: plan.push_back(P_BR);
         6'b000010: plan.push_back(P_J);
         6'b000011: plan.push_back(P_JAL);
         default:   begin plan.push_back(P_EXI); plan.push_back(P_WBI); end
      endcase
      foreach (plan[i]) begin
         if (plan[i] == P_IF || plan[i] == P_MRD || plan[i] == P_MWR) begin
            w = (plan[i] == P_IF) ? wif : wmem;
            if (w < 0) w = $urandom_range(0, 3);
            repeat (w) step(plan[i], ins, 1'b0, zf);
            step(plan[i], ins, 1'b1, zf);
         end else begin
            step(plan[i], ins, 1'($urandom), zf);
         end
      end
      exp_cnt = exp_cnt + 1'b1;
      check_cnt("retire");
   endtask

   task automatic do_reset();
      rst = 1'b0;
      mem_ready = 1'($urandom); instruction = $urandom;
      exp_cnt = '0; exp_err = 1'b0; exp_code = 2'b00;
      #2;
      checks++;
      if (observed() !== 22'd0 || instr_count !== '0) begin
         errors++;
         $display("FAIL reset outputs: got %b cnt %0d want all zero", observed(), instr_count);
      end
      @(posedge clk); #1;
      rst = 1'b1;
   endtask

   function automatic logic [31:0] rand_legal();
      logic [5:0] fns [5];
      logic [31:0] r;
      fns = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
      r = $urandom;
      case ($urandom_range(0, 10))
         0:  return {6'b000000, r[25:6], fns[$urandom_range(0, 4)]};
         1:  return {6'b000000, r[25:6], 6'b001000};
         2:  return {6'b001000, r[25:0]};
         3:  return {6'b001100, r[25:0]};
         4:  return {6'b001010, r[25:0]};
         5:  return {6'b100011, r[25:0]};
         6:  return {6'b101011, r[25:0]};
         7:  return {6'b000100, r[25:0]};
         8:  return {6'b000101, r[25:0]};
         9:  return {6'b000010, r[25:0]};
         default: return {6'b000011, r[25:0]};
      endcase
   endfunction

   task automatic test_reset();
      @(posedge clk); #1;
      do_reset();
   endtask

   task automatic test_add();
      run_instr(I_ADD, 1'b0, 0, 0);
   endtask

   task automatic test_lw_wait();
      run_instr(I_LW, 1'b0, 0, 3);
      run_instr(I_SW, 1'b0, 2, 2);
   endtask

   task automatic test_branch();
      run_instr(I_BNE, 1'b1, 0, 0);
      run_instr(I_BNE, 1'b0, 0, 0);
      run_instr(I_BEQ, 1'b1, 0, 0);
      run_instr(I_BEQ, 1'b0, 0, 0);
      run_instr(I_JR,  1'b0, 0, 0);
   endtask

   task automatic test_random();
      for (int n = 0; n < 40; n++) run_instr(rand_legal(), 1'($urandom), -1, -1);
   endtask

   task automatic test_illegal(input logic [31:0] ins);
      step(P_IF, ins, 1'b1, 1'b0);
      step(P_ID, ins, 1'b1, 1'b0);
      exp_err = 1'b1; exp_code = 2'b01;
      repeat (4) step(P_ERR, ins, 1'($urandom), 1'($urandom));
      check_cnt("illegal");
      do_reset();
   endtask

   task automatic test_timeout();
      repeat (15) step(P_IF, I_ADD, 1'b0, 1'b0);
      exp_err = 1'b1; exp_code = 2'b10;
      repeat (3) step(P_ERR, I_ADD, 1'b0, 1'b0);
      repeat (3) step(P_ERR, I_ADD, 1'b1, 1'b0);
      do_reset();
      run_instr(I_ADD, 1'b0, 14, 0);  // last allowed wait, ready just in time
   endtask

   task automatic test_wrap_and_abort();
      do_reset();
      for (int n = 0; n < (1 << CW) - 1; n++) run_instr(I_J, 1'b0, 0, 0);
      run_instr(I_J, 1'b0, 0, 0);
      run_instr(I_J, 1'b0, 0, 0);
      step(P_IF, I_SW, 1'b1, 1'b0);
      step(P_ID, I_SW, 1'b1, 1'b0);
      step(P_MA, I_SW, 1'b1, 1'b0);
      step(P_MWR, I_SW, 1'b0, 1'b0);
      do_reset();
      run_instr(I_ADD, 1'b0, 0, 0);
   endtask

   initial begin
      test_reset();
      test_add();
      test_lw_wait();
      test_branch();
      test_random();
      test_illegal(32'hFC00_0000);
      test_illegal(32'h0000_003F);
      test_timeout();
      test_wrap_and_abort();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
